// File: rtl/reg_display_ctrl.sv
// -----------------------------------------------------------------------------
// reg_display_ctrl
//
// Run-control and register-display controller for the computer core.
//   * Generates the core clock-enable (cpu_en) with a programmable rate in run
//     mode, one pulse per button press in single-step mode, none in halt.
//   * After every core step, snapshots the whole register bank into a shadow
//     copy so the display always shows post-step values.
//   * Round-robins the shadow copy onto a display/GPIO output, one register
//     every SCAN_CYCLES clocks.
//
// Optional feature (macro REG_DISPLAY_BREAKPOINT_EN): a register-0 breakpoint
// that stops run mode once a snapshot of register 0 equals bp_value.
//
// Ports:
//   clock        system clock
//   reset        synchronous reset, active-low
//   div_limit    run-mode cpu_en period is div_limit+1 clocks
//   mode         00 halt, 01 run, 10 single-step, 11 halt
//   step_btn     single-step request (level, rising-edge detected)
//   regs_in      flattened register bank, reg k at [k*REG_WIDTH +: REG_WIDTH]
//   bp_value     breakpoint compare value (macro only)
//   bp_hit       breakpoint reached, run mode suppressed (macro only)
//   cpu_en       one-cycle enable pulse to the core
//   heartbeat    toggles on every cpu_en
//   step_count   number of cpu_en pulses issued (wraps)
//   snap_valid   at least one snapshot has been taken
//   disp_sel     index of the register shown on disp_data
//   disp_data    snapshot value of register disp_sel
//   disp_strobe  one-cycle pulse when disp_sel/disp_data update
// -----------------------------------------------------------------------------
module reg_display_ctrl #(
  parameter int NUM_REGS    = 8,
  parameter int REG_WIDTH   = 16,
  parameter int DIV_WIDTH   = 24,
  parameter int SCAN_CYCLES = 1024
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DIV_WIDTH-1:0]            div_limit,
  input  logic [1:0]                      mode,
  input  logic                            step_btn,
  input  logic [NUM_REGS*REG_WIDTH-1:0]   regs_in,
`ifdef REG_DISPLAY_BREAKPOINT_EN
  input  logic [REG_WIDTH-1:0]            bp_value,
  output logic                            bp_hit,
`endif
  output logic                            cpu_en,
  output logic                            heartbeat,
  output logic [31:0]                     step_count,
  output logic                            snap_valid,
  output logic [$clog2(NUM_REGS)-1:0]     disp_sel,
  output logic [REG_WIDTH-1:0]            disp_data,
  output logic                            disp_strobe
);

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam int SEL_W  = $clog2(NUM_REGS);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_REGS - 1);

  // Unpacked view of the flattened register bank
  logic [REG_WIDTH-1:0] regs_arr [NUM_REGS];
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_unpack
    assign regs_arr[k] = regs_in[k*REG_WIDTH +: REG_WIDTH];
  end

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic                 cpu_en_q, cpu_en_d;
  logic                 cpu_en_dly_q;
  logic                 step_prev_q;
  logic                 heartbeat_q;
  logic [31:0]          step_count_q;
  logic                 snap_valid_q;
  logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [SEL_W-1:0]     disp_sel_q, disp_sel_d;
  logic [REG_WIDTH-1:0] disp_data_q, disp_data_d;
  logic                 disp_strobe_q;

  logic                 run_en;
  logic                 step_edge;
  logic                 capture;
  logic                 scan_wrap;
  logic [SEL_W-1:0]     sel_next;

`ifdef REG_DISPLAY_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  assign run_en = (mode == MODE_RUN) && !bp_hit_q;

  // Halt always releases the breakpoint, even if a matching snapshot lands
  // in the same cycle.
  always_comb begin
    bp_hit_d = bp_hit_q;
    if (mode == MODE_HALT) begin
      bp_hit_d = 1'b0;
    end else if (capture && (regs_arr[0] == bp_value)) begin
      bp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  assign run_en = (mode == MODE_RUN);
`endif

  assign step_edge = step_btn & ~step_prev_q;

  // Divider / step logic: the count is held at 0 outside active run, so any
  // mode change into run always starts a fresh full period.
  always_comb begin
    div_cnt_d = '0;
    cpu_en_d  = 1'b0;
    if (run_en) begin
      // >= (not ==) so lowering div_limit below the count ticks at once
      if (div_cnt_q >= div_limit) begin
        cpu_en_d = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end else if (mode == MODE_STEP) begin
      cpu_en_d = step_edge;
    end
  end

  // Capture one cycle after cpu_en so the core has already updated regs_in.
  assign capture   = cpu_en_dly_q;
  assign scan_wrap = (scan_cnt_q == SCAN_LAST);
  assign sel_next  = (disp_sel_q == SEL_LAST) ? '0 : disp_sel_q + 1'b1;

  always_comb begin
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    disp_sel_d  = disp_sel_q;
    disp_data_d = disp_data_q;
    if (scan_wrap) begin
      disp_sel_d  = sel_next;
      // Bypass the shadow when it is being rewritten this same cycle
      disp_data_d = capture ? regs_arr[sel_next] : shadow_q[sel_next];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q     <= '0;
      cpu_en_q      <= 1'b0;
      cpu_en_dly_q  <= 1'b0;
      step_prev_q   <= 1'b0;
      heartbeat_q   <= 1'b0;
      step_count_q  <= '0;
      snap_valid_q  <= 1'b0;
      scan_cnt_q    <= '0;
      disp_sel_q    <= '0;
      disp_data_q   <= '0;
      disp_strobe_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      // Stage: pulse generation and per-step counters
      div_cnt_q    <= div_cnt_d;
      cpu_en_q     <= cpu_en_d;
      step_prev_q  <= step_btn;
      if (cpu_en_d) begin
        heartbeat_q  <= ~heartbeat_q;
        step_count_q <= step_count_q + 32'd1;
      end
      // Stage: delayed enable and snapshot
      cpu_en_dly_q <= cpu_en_q;
      if (capture) begin
        shadow_q     <= regs_arr;
        snap_valid_q <= 1'b1;
      end
      // Stage: display scanner
      scan_cnt_q    <= scan_cnt_d;
      disp_sel_q    <= disp_sel_d;
      disp_data_q   <= disp_data_d;
      disp_strobe_q <= scan_wrap;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign heartbeat   = heartbeat_q;
  assign step_count  = step_count_q;
  assign snap_valid  = snap_valid_q;
  assign disp_sel    = disp_sel_q;
  assign disp_data   = disp_data_q;
  assign disp_strobe = disp_strobe_q;

endmodule

// File: tb/tb_reg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_display_ctrl
//
// Directed bench for reg_display_ctrl (NUM_REGS=8, SCAN_CYCLES=4).
// Expected cpu_en pulse cycles are queued when stimulus is applied; a small
// reference model of the snapshot bank and scanner queues expected display
// updates; both are popped and compared when the DUT produces output.
// Breakpoint checks are compiled only with REG_DISPLAY_BREAKPOINT_EN.
// -----------------------------------------------------------------------------
module tb_reg_display_ctrl;

  localparam int NR = 8;
  localparam int RW = 16;
  localparam int DW = 24;
  localparam int SC = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [DW-1:0]    div_limit;
  logic [1:0]       mode;
  logic             step_btn;
  logic [NR*RW-1:0] regs_in;
  logic             cpu_en;
  logic             heartbeat;
  logic [31:0]      step_count;
  logic             snap_valid;
  logic [2:0]       disp_sel;
  logic [RW-1:0]    disp_data;
  logic             disp_strobe;
`ifdef REG_DISPLAY_BREAKPOINT_EN
  logic [RW-1:0]    bp_value;
  logic             bp_hit;
`endif

  reg_display_ctrl #(
    .NUM_REGS(NR), .REG_WIDTH(RW), .DIV_WIDTH(DW), .SCAN_CYCLES(SC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .div_limit(div_limit),
    .mode(mode),
    .step_btn(step_btn),
    .regs_in(regs_in),
`ifdef REG_DISPLAY_BREAKPOINT_EN
    .bp_value(bp_value),
    .bp_hit(bp_hit),
`endif
    .cpu_en(cpu_en),
    .heartbeat(heartbeat),
    .step_count(step_count),
    .snap_valid(snap_valid),
    .disp_sel(disp_sel),
    .disp_data(disp_data),
    .disp_strobe(disp_strobe)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_steps = 0;

  int en_q[$];
  int cap_q[$];
  int sel_q[$];
  int data_q[$];

  logic [RW-1:0] m_shadow [NR];
  int            m_scan = 0;
  int            m_sel = 0;
  logic [RW-1:0] m_data = '0;
  logic          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse expected in sample cycle c; its snapshot lands on edge c+2
  task automatic expect_pulse(input int c);
    en_q.push_back(c);
    cap_q.push_back(c + 2);
    exp_steps++;
  endtask

  task automatic set_regs(input int base);
    for (int k = 0; k < NR; k++) regs_in[k*RW +: RW] = RW'(base + k);
  endtask

  task automatic chk_counts();
    chk("step_count", step_count, exp_steps);
    chk("heartbeat", heartbeat, exp_steps % 2);
  endtask

  task automatic tick();
    int s;
    int d;
    @(posedge clock);
    cyc++;
    if (!reset) begin
      m_scan = 0; m_sel = 0; m_data = '0; m_valid = 1'b0;
      for (int k = 0; k < NR; k++) m_shadow[k] = '0;
      cap_q.delete();
    end else begin
      if (cap_q.size() > 0 && cap_q[0] == cyc) begin
        void'(cap_q.pop_front());
        for (int k = 0; k < NR; k++) m_shadow[k] = regs_in[k*RW +: RW];
        m_valid = 1'b1;
      end
      if (m_scan == SC - 1) begin
        m_scan = 0;
        m_sel  = (m_sel + 1) % NR;
        m_data = m_shadow[m_sel];
        sel_q.push_back(m_sel);
        data_q.push_back(int'(m_data));
      end else begin
        m_scan++;
      end
    end
    #1;
    if (cpu_en) begin
      chk("cpu_en_cycle", (en_q.size() > 0) ? en_q[0] : -1, cyc);
      if (en_q.size() > 0) void'(en_q.pop_front());
    end else if (en_q.size() > 0 && en_q[0] <= cyc) begin
      chk("cpu_en_missing", cpu_en, 1'b1);
      void'(en_q.pop_front());
    end
    if (disp_strobe) begin
      chk("strobe_expected", sel_q.size() > 0, 1'b1);
      if (sel_q.size() > 0) begin
        s = sel_q.pop_front();
        d = data_q.pop_front();
        chk("strobe_sel", disp_sel, s);
        chk("strobe_data", disp_data, d);
      end
    end else if (sel_q.size() > 0) begin
      chk("strobe_missing", disp_strobe, 1'b1);
      void'(sel_q.pop_front());
      void'(data_q.pop_front());
    end
    chk("disp_sel", disp_sel, m_sel);
    chk("disp_data", disp_data, m_data);
    chk("snap_valid", snap_valid, m_valid);
  endtask

  initial begin
    int n;
    reset = 1'b0; mode = 2'b00; div_limit = '0; step_btn = 1'b0; regs_in = '0;
`ifdef REG_DISPLAY_BREAKPOINT_EN
    bp_value = 16'h0007;
`endif

    // Reset and idle
    repeat (3) tick();
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_heartbeat", heartbeat, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_disp_sel", disp_sel, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_disp_strobe", disp_strobe, 0);
    reset = 1'b1;
    repeat (100) tick();
    chk("idle_step_count", step_count, 0);
    chk("idle_heartbeat", heartbeat, 0);
    chk("idle_snap_valid", snap_valid, 0);

    // Run rate: div_limit=4 for 50 clocks -> 10 pulses
    set_regs(16'h2000);
    run_for(4, 50);
    chk("run_step_count", step_count, 10);
    chk("run_heartbeat", heartbeat, 0);
    repeat (3) tick();
    chk("run_snap_valid", snap_valid, 1);

    // Step: held button gives one pulse, second press another
    mode = 2'b10;
    repeat (2) tick();
    step_btn = 1'b1; expect_pulse(cyc + 1);
    repeat (20) tick();
    step_btn = 1'b0;
    repeat (5) tick();
    step_btn = 1'b1; expect_pulse(cyc + 1);
    repeat (3) tick();
    step_btn = 1'b0;
    repeat (2) tick();
    chk("step_count_after_step", step_count, 12);
    chk_counts();

    // Step straight into run: divider starts from 0
    step_btn = 1'b1; expect_pulse(cyc + 1);
    tick();
    step_btn = 1'b0;
    tick();
    run_for(4, 5);

    // div_limit = 0: a pulse every clock
    run_for(0, 3);

    // Lowering div_limit below the running count ticks next cycle
    div_limit = 24'd9; mode = 2'b01;
    repeat (6) tick();
    div_limit = 24'd2;
    expect_pulse(cyc + 1);
    expect_pulse(cyc + 4);
    repeat (4) tick();
    mode = 2'b00;

    // Halting mid-count discards the partial count
    div_limit = 24'd4; mode = 2'b01;
    repeat (3) tick();
    mode = 2'b00;
    repeat (2) tick();
    run_for(4, 5);
    repeat (3) tick();
    chk_counts();

    // Snapshot and full scan of reg k = 0x1000+k
    set_regs(16'h1000);
    mode = 2'b10;
    tick();
    step_btn = 1'b1; expect_pulse(cyc + 1);
    tick();
    step_btn = 1'b0;
    repeat (40) tick();
    chk("snap_snap_valid", snap_valid, 1);

    // Bypass: capture and wrap onto index 3 on the same edge
    regs_in[3*RW +: RW] = 16'hAAAA;
    step_btn = 1'b1; expect_pulse(cyc + 1);
    tick();
    step_btn = 1'b0;
    repeat (4) tick();
    regs_in[3*RW +: RW] = 16'h5555;
    n = 0;
    while (!(m_sel == 2 && m_scan == 1) && n < 64) begin
      tick();
      n++;
    end
    chk("align_in_budget", n < 64, 1'b1);
    step_btn = 1'b1; expect_pulse(cyc + 1);
    repeat (3) tick();
    chk("bypass_sel", disp_sel, 3);
    chk("bypass_data", disp_data, 16'h5555);
    step_btn = 1'b0;
    repeat (6) tick();
    mode = 2'b00;
    chk_counts();

`ifdef REG_DISPLAY_BREAKPOINT_EN
    // Breakpoint on reg 0 == 7 stops run mode until a halt
    set_regs(16'h3000);
    div_limit = 24'd1; mode = 2'b01;
    expect_pulse(cyc + 2); expect_pulse(cyc + 4); expect_pulse(cyc + 6);
    repeat (4) tick();
    regs_in[RW-1:0] = 16'h0007;
    repeat (2) tick();
    chk("bp_set", bp_hit, 1);
    repeat (12) tick();
    chk("bp_held", bp_hit, 1);
    mode = 2'b00;
    regs_in[RW-1:0] = 16'h3000;
    tick();
    chk("bp_clear", bp_hit, 0);
    mode = 2'b01;
    expect_pulse(cyc + 2);
    repeat (2) tick();
    mode = 2'b00;
    repeat (3) tick();
    chk("bp_stays_clear", bp_hit, 0);
    chk_counts();
`endif

    chk("no_pending_pulses", en_q.size(), 0);

    // Reset again clears everything
    reset = 1'b0;
    repeat (2) tick();
    chk("rst2_step_count", step_count, 0);
    chk("rst2_heartbeat", heartbeat, 0);
    chk("rst2_snap_valid", snap_valid, 0);
    chk("rst2_disp_sel", disp_sel, 0);
    chk("rst2_disp_data", disp_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic run_for(input int lim, input int n);
    div_limit = DW'(lim);
    mode = 2'b01;
    for (int k = 1; (lim + 1) * k <= n; k++) expect_pulse(cyc + (lim + 1) * k);
    repeat (n) tick();
    mode = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_display_ctrl.md
Name: reg_display_ctrl

Overview:
- Parametrised run-control and register-display controller for the computer core.
- Generates the core's clock-enable pulse, with programmable rate and run/halt/single-step modes.
- Snapshots an N-register bank after each core step, then round-robins the snapshot to a display/GPIO output one register at a time.
- Replaces the fixed clock divider and fixed eight-register output path with a generalised, controllable block.

Parameters:
NUM_REGS, 8, number of register channels captured and scanned (>=2)
REG_WIDTH, 16, width of each register
DIV_WIDTH, 24, width of the rate divider and of div_limit
SCAN_CYCLES, 1024, clocks each register is held on the display output (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-low
div_limit  in  DIV_WIDTH  cpu_en period is div_limit+1 clocks in run mode
mode  in  2  00 halt, 01 run, 10 single-step, 11 treated as halt
step_btn  in  1  single-step request, level input, rising-edge detected
regs_in  in  NUM_REGS*REG_WIDTH  flattened register bank, reg k at [k*REG_WIDTH +: REG_WIDTH]
cpu_en  out  1  one-cycle enable pulse to the core
heartbeat  out  1  toggles on every cpu_en
step_count  out  32  number of cpu_en pulses issued, wraps
snap_valid  out  1  high once at least one snapshot exists
disp_sel  out  clog2(NUM_REGS)  index of the register on disp_data
disp_data  out  REG_WIDTH  snapshot value of register disp_sel
disp_strobe  out  1  one-cycle pulse when disp_sel/disp_data update

Behaviour:
- Reset (reset==0 at a clock edge) clears all outputs, the divider, scan counter, shadow bank and step-edge register to 0.
- Run (01):
  - Divider counts up each clock.
  - When count >= div_limit: cpu_en=1 for that cycle and count returns to 0.
  - div_limit=0 gives cpu_en every cycle.
  - Lowering div_limit below the current count causes a tick on the next cycle.
- Halt (00/11): count held at 0, cpu_en=0. Leaving run mid-count discards the partial count.
- Step (10):
  - Divider held at 0.
  - step_prev registers step_btn; edge = step_btn & ~step_prev.
  - Each edge produces exactly one cpu_en on the following cycle. A held button gives one pulse only.
- Mode switching directly from step to run starts the divider from 0.
- cpu_en side effects: heartbeat toggles and step_count increments in the same cycle as cpu_en.
- Snapshot:
  - cpu_en_d is cpu_en delayed one cycle.
  - When cpu_en_d=1, all NUM_REGS words of regs_in are captured into the shadow bank, so the snapshot reflects post-step register values.
  - snap_valid is set on the first capture and stays set until reset.
- Scanner:
  - Free-running counter counts 0..SCAN_CYCLES-1 in every mode.
  - On wrap: disp_sel advances by 1, modulo NUM_REGS (NUM_REGS-1 -> 0); disp_data loads the shadow value of the new index; disp_strobe=1 for one cycle.
  - First wrap after reset shows index 1.
- Simultaneous capture and scan wrap: disp_data takes the newly captured value (bypass), never the stale shadow entry.
- disp_data is otherwise stable between strobes. A capture on a non-wrap cycle does not change disp_data until the next strobe.
- All outputs are registered except cpu_en, which is a registered pulse from the divider/edge logic. No combinational path from inputs to outputs.

Optional Feature:
- Macro: REG_DISPLAY_BREAKPOINT_EN.
- With the macro defined:
  - Extra ports: bp_value in REG_WIDTH, bp_hit out 1 (reset 0).
  - At each snapshot, if captured reg 0 == bp_value, bp_hit sets.
  - While bp_hit=1, run mode produces no cpu_en and the divider is held at 0.
  - Single-step still works while bp_hit=1.
  - bp_hit clears on any cycle where mode==00.
- Without the macro: no bp ports, and run mode is never suppressed.

Test Plan:
- Reset and idle: reset=0 for 3 clocks, then mode=00 for 100 clocks -> all outputs 0, no cpu_en, step_count=0.
- Run rate: mode=01, div_limit=4 for 50 clocks -> cpu_en every 5th clock, 10 pulses, step_count=10, heartbeat=0.
- Step debounce: mode=10; step_btn high 20 clocks, low 5, high 3 -> exactly 2 cpu_en pulses, each one cycle after its rising edge.
- Snapshot/scan:
  - Setup: NUM_REGS=8, SCAN_CYCLES=4; regs_in reg k = 16'h1000+k; one step.
  - Expected: snap_valid=1; disp_sel sequence 1,2,...,7,0; disp_data = 16'h1000+disp_sel; disp_strobe every 4 clocks.
- Bypass collision: align cpu_en_d with a scan wrap onto index 3 while reg 3 changes 16'hAAAA -> 16'h5555 -> disp_data=16'h5555 at that strobe.
- Breakpoint (macro on): bp_value=16'h0007; reg 0 reaches 7 in run mode -> bp_hit=1 and no further cpu_en; mode=00 for one clock -> bp_hit=0; mode=01 -> pulses resume.
